// File: rtl/control_unit_pkg.sv
// Shared opcode values, FSM states and instruction field positions.
package control_unit_pkg;

  localparam int unsigned OP_BITS  = 5;
  localparam int unsigned SEL_BITS = 3;

  localparam int unsigned OP_LSB   = 27;
  localparam int unsigned RD_LSB   = 24;
  localparam int unsigned RA_LSB   = 21;
  localparam int unsigned RB_LSB   = 18;
  localparam int unsigned ADDR_LSB = 0;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_O = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [OP_BITS-1:0] {
    OP_NOP = 5'd0,  OP_NOT = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3,
    OP_XOR = 5'd4,  OP_NEG = 5'd5,  OP_ADD = 5'd6,  OP_SUB = 5'd7,
    OP_MUL = 5'd8,  OP_DIV = 5'd9,  OP_MOD = 5'd10, OP_JMP = 5'd11,
    OP_JC  = 5'd12, OP_JS  = 5'd13, OP_JO  = 5'd14, OP_JZ  = 5'd15,
    OP_LD  = 5'd16, OP_STR = 5'd17, OP_HLT = 5'd18
  } op_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALTED
  } state_e;

  // Opcodes whose result is written back to rd and updates the flags.
  function automatic logic is_alu_op(logic [OP_BITS-1:0] op);
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB, OP_MUL: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // XOR/DIV/MOD are decoded as illegal along with unassigned encodings.
  function automatic logic is_legal(logic [OP_BITS-1:0] op);
    case (op)
      OP_XOR, OP_DIV, OP_MOD: return 1'b0;
      default:                return (op <= OP_HLT);
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Single-port memory bus between the sequencer (master) and memory (slave).
interface control_unit_if #(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16
);
  logic [BITS_ADDR-1:0] mem_addr;
  logic                 mem_rd;
  logic                 mem_wr;
  logic [BITS_DATA-1:0] mem_wdata;
  logic [BITS_DATA-1:0] mem_rdata;
  logic                 mem_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/control_unit_register_file.sv
// General register file: two asynchronous read ports, one synchronous write port.
module control_unit_register_file #(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned SEL_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_BITS-1:0]  rd_sel_a,
  input  logic [SEL_BITS-1:0]  rd_sel_b,
  output logic [BITS_DATA-1:0] rd_data_a,
  output logic [BITS_DATA-1:0] rd_data_b,
  input  logic                 wr_en,
  input  logic [SEL_BITS-1:0]  wr_sel,
  input  logic [BITS_DATA-1:0] wr_data
);

  logic [BITS_DATA-1:0] regs [NUM_REGS];

  assign rd_data_a = regs[rd_sel_a];
  assign rd_data_b = regs[rd_sel_b];

  // Clear every register on reset, otherwise write the selected one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_sel] <= wr_data;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving an external combinational ALU.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16,
  parameter int unsigned NUM_REGS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_unit_if.master       mem_bus,
  output logic [BITS_DATA-1:0] alu_a,
  output logic [BITS_DATA-1:0] alu_b,
  output logic [OP_BITS-1:0]   alu_opcode,
  input  logic [BITS_DATA-1:0] alu_result,
  input  logic                 alu_c,
  input  logic                 alu_s,
  input  logic                 alu_o,
  input  logic                 alu_z,
  output logic [3:0]           flags,
  output logic [BITS_ADDR-1:0] pc,
  output logic                 halted,
  output logic                 illegal_op
);

  state_e                state;
  logic [OP_BITS-1:0]    ir_op;
  logic [SEL_BITS-1:0]   ir_rd;
  logic [SEL_BITS-1:0]   ir_ra;
  logic [SEL_BITS-1:0]   ir_rb;
  logic [BITS_ADDR-1:0]  ir_addr;

  logic [SEL_BITS-1:0]   rf_sel_a;
  logic [BITS_DATA-1:0]  rf_a;
  logic [BITS_DATA-1:0]  rf_b;
  logic                  rf_wr_en;
  logic [BITS_DATA-1:0]  rf_wr_data;
  logic                  is_ld;
  logic                  take_jump;
  logic [BITS_ADDR-1:0]  next_pc;

  assign is_ld    = (ir_op == OP_LD);
  // Port a reads ra for the ALU in DECODE and rd as store data in EXEC.
  assign rf_sel_a = (state == ST_EXEC) ? ir_rd : ir_ra;
  assign next_pc  = take_jump ? ir_addr : pc;

  control_unit_register_file #(
    .BITS_DATA (BITS_DATA),
    .NUM_REGS  (NUM_REGS),
    .SEL_BITS  (SEL_BITS)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_sel_a  (rf_sel_a),
    .rd_sel_b  (ir_rb),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .wr_en     (rf_wr_en),
    .wr_sel    (ir_rd),
    .wr_data   (rf_wr_data)
  );

  // Register write-back: ALU result in EXEC, load data on the LD ack.
  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_data = alu_result;
    if (state == ST_EXEC && is_alu_op(ir_op)) begin
      rf_wr_en = 1'b1;
    end else if (state == ST_MEM && mem_bus.mem_rd && mem_bus.mem_ack) begin
      rf_wr_en   = 1'b1;
      rf_wr_data = mem_bus.mem_rdata;
    end
  end

  // Branch condition from the flag register.
  always_comb begin
    take_jump = 1'b0;
    case (ir_op)
      OP_JMP:  take_jump = 1'b1;
      OP_JC:   take_jump = flags[FLAG_C];
      OP_JS:   take_jump = flags[FLAG_S];
      OP_JO:   take_jump = flags[FLAG_O];
      OP_JZ:   take_jump = flags[FLAG_Z];
      default: take_jump = 1'b0;
    endcase
  end

  // Sequencer FSM with registered bus, ALU and status outputs.
  // Bus requests are raised on the edge that enters FETCH/MEM so a zero-wait
  // memory completes in the same state; only the first fetch after reset
  // needs an extra cycle to raise mem_rd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_FETCH;
      pc                <= '0;
      ir_op             <= '0;
      ir_rd             <= '0;
      ir_ra             <= '0;
      ir_rb             <= '0;
      ir_addr           <= '0;
      flags             <= '0;
      alu_a             <= '0;
      alu_b             <= '0;
      alu_opcode        <= OP_NOP;
      halted            <= 1'b0;
      illegal_op        <= 1'b0;
      mem_bus.mem_rd    <= 1'b0;
      mem_bus.mem_wr    <= 1'b0;
      mem_bus.mem_addr  <= '0;
      mem_bus.mem_wdata <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!mem_bus.mem_rd) begin
            mem_bus.mem_rd   <= 1'b1;
            mem_bus.mem_addr <= pc;
          end else if (mem_bus.mem_ack) begin
            ir_op          <= mem_bus.mem_rdata[OP_LSB +: OP_BITS];
            ir_rd          <= mem_bus.mem_rdata[RD_LSB +: SEL_BITS];
            ir_ra          <= mem_bus.mem_rdata[RA_LSB +: SEL_BITS];
            ir_rb          <= mem_bus.mem_rdata[RB_LSB +: SEL_BITS];
            ir_addr        <= mem_bus.mem_rdata[ADDR_LSB +: BITS_ADDR];
            pc             <= pc + BITS_ADDR'(1);
            mem_bus.mem_rd <= 1'b0;
            state          <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_a      <= rf_a;
          alu_b      <= rf_b;
          alu_opcode <= ir_op;
          if (!is_legal(ir_op)) begin
            illegal_op <= 1'b1;
            halted     <= 1'b1;
            state      <= ST_HALTED;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_alu_op(ir_op)) begin
            flags <= {alu_c & (ir_op != OP_MUL), alu_s, alu_o, alu_z};
          end
          if (ir_op == OP_HLT) begin
            halted <= 1'b1;
            state  <= ST_HALTED;
          end else if (ir_op == OP_LD || ir_op == OP_STR) begin
            mem_bus.mem_addr  <= ir_addr;
            mem_bus.mem_rd    <= is_ld;
            mem_bus.mem_wr    <= ~is_ld;
            mem_bus.mem_wdata <= rf_a;
            state             <= ST_MEM;
          end else begin
            pc               <= next_pc;
            mem_bus.mem_rd   <= 1'b1;
            mem_bus.mem_addr <= next_pc;
            state            <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (mem_bus.mem_ack) begin
            mem_bus.mem_wr   <= 1'b0;
            mem_bus.mem_rd   <= 1'b1;
            mem_bus.mem_addr <= pc;
            state            <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
